// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between requesters and the round-robin arbiter
interface rr_grant_arbiter_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             preempt;
  modport master (input req, output grant, grant_idx, grant_valid, preempt);
  modport slave  (output req, input grant, grant_idx, grant_valid, preempt);
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with registered one-hot/index grant and optional hold limit
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W    = $clog2(N)
) (
  input logic               clk,
  input logic               rst_n,
  rr_grant_arbiter_if.master bus
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state, state_nx;
  logic [N-1:0]     grant_q, grant_nx, own_mask, mask;
  logic [IDX_W-1:0] idx_q, idx_nx, last_idx, last_nx, base, win, cand;
  logic             valid_q, valid_nx, preempt_q, preempt_nx, found;
  logic             rel, at_limit, others, do_pre;
  logic [HW-1:0]    hold_cnt, hold_nx;
  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.preempt     = preempt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      hold_cnt  <= '0;
      last_idx  <= IDX_W'(N - 1);
    end else begin
      state     <= state_nx;
      grant_q   <= grant_nx;
      idx_q     <= idx_nx;
      valid_q   <= valid_nx;
      preempt_q <= preempt_nx;
      hold_cnt  <= hold_nx;
      last_idx  <= last_nx;
    end
  // The owner is idx_q while in GRANT; scanning starts just after the owner on a handover.
  always_comb begin
    own_mask = N'(1) << idx_q;
    rel      = state == GRANT && !bus.req[idx_q];
    at_limit = MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD - 1);
    others   = |(bus.req & ~own_mask);
    do_pre   = state == GRANT && !rel && at_limit && others;
    base     = (rel || do_pre) ? idx_q : last_idx;
    mask     = do_pre ? bus.req & ~own_mask : bus.req;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(base) + k) % N);
      if (!found && mask[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
  always_comb begin
    state_nx   = state;
    grant_nx   = grant_q;
    idx_nx     = idx_q;
    valid_nx   = valid_q;
    preempt_nx = 1'b0;
    hold_nx    = hold_cnt;
    last_nx    = last_idx;
    if (state == IDLE || rel || do_pre) begin
      state_nx   = found ? GRANT : IDLE;
      grant_nx   = found ? N'(1) << win : '0;
      idx_nx     = found ? win : '0;
      valid_nx   = found;
      preempt_nx = do_pre;
      hold_nx    = '0;
      last_nx    = state == IDLE ? last_idx : idx_q;
    end else if (at_limit)
      hold_nx = '0;
    else if (MAX_HOLD != 0)
      hold_nx = hold_cnt + HW'(1);
  end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed and random checks of two arbiter instances (no limit, limit 4) against a model
module tb_rr_grant_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int passes = 0;
  int m_owner[2], m_last[2], m_run[2], m_pre[2];
  int mh[2] = '{0, 4};
  rr_grant_arbiter_if #(.N(4)) b0 ();
  rr_grant_arbiter_if #(.N(4)) b1 ();
  rr_grant_arbiter #(.N(4), .MAX_HOLD(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  rr_grant_arbiter #(.N(4), .MAX_HOLD(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic int pick(input int base, input logic [3:0] r, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c = (base + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction
  // Model: owner -1 means idle; run counts cycles the current grant has been visible.
  task automatic mstep(input int d, input logic [3:0] r);
    m_pre[d] = 0;
    if (m_owner[d] < 0) begin
      m_owner[d] = pick(m_last[d], r, -1);
      m_run[d] = 1;
    end else if (!r[m_owner[d]]) begin
      m_last[d] = m_owner[d];
      m_owner[d] = pick(m_last[d], r, -1);
      m_run[d] = 1;
    end else if (mh[d] != 0 && m_run[d] == mh[d]) begin
      if ((r & ~(4'b1 << m_owner[d])) != 4'b0) begin
        m_last[d] = m_owner[d];
        m_owner[d] = pick(m_last[d], r, m_owner[d]);
        m_pre[d] = 1;
      end
      m_run[d] = 1;
    end else m_run[d]++;
  endtask
  task automatic chk_dut(input int d, input logic [3:0] g, input logic [1:0] i, input logic v, input logic p);
    int o = m_owner[d];
    chk($sformatf("dut%0d_grant", d), 32'(g), o < 0 ? 0 : 1 << o);
    chk($sformatf("dut%0d_idx", d), 32'(i), o < 0 ? 0 : o);
    chk($sformatf("dut%0d_valid", d), 32'(v), o < 0 ? 0 : 1);
    chk($sformatf("dut%0d_preempt", d), 32'(p), m_pre[d]);
  endtask
  task automatic check_all();
    chk_dut(0, b0.grant, b0.grant_idx, b0.grant_valid, b0.preempt);
    chk_dut(1, b1.grant, b1.grant_idx, b1.grant_valid, b1.preempt);
  endtask
  task automatic cyc();
    @(posedge clk);
    mstep(0, b0.req);
    mstep(1, b1.req);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d] = 3;
      m_run[d] = 0;
      m_pre[d] = 0;
    end
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    b0.req = '0;
    b1.req = '0;
    do_reset();
    // 1: no-bubble handover on release
    b0.req = 4'b0101;
    cyc();
    chk("t1_grant0", 32'(b0.grant), 32'h1);
    b0.req = 4'b0100;
    cyc();
    chk("t1_grant2", 32'(b0.grant), 32'h4);
    chk("t1_valid", 32'(b0.grant_valid), 32'h1);
    b0.req = 4'b0000;
    cyc();
    // 2: rotation through all requesters
    do_reset();
    b0.req = 4'hF;
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("t2_idx_first", 32'(b0.grant_idx), i % 4);
      cyc();
      chk("t2_idx_second", 32'(b0.grant_idx), i % 4);
      b0.req[i % 4] = 1'b0;
      cyc();
      b0.req = 4'hF;
    end
    b0.req = '0;
    // 3: hold limit forces alternation with preempt pulses
    do_reset();
    b1.req = 4'b0011;
    cyc();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        chk("t3_idx", 32'(b1.grant_idx), r % 2);
        chk("t3_preempt", 32'(b1.preempt), (c == 0 && r > 0) ? 1 : 0);
        cyc();
      end
    // 4: lone requester keeps the grant past the limit
    do_reset();
    b1.req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      cyc();
      chk("t4_grant", 32'(b1.grant), 32'h1);
      chk("t4_preempt", 32'(b1.preempt), 32'h0);
    end
    // 5: release on the limit cycle is a plain release
    do_reset();
    b1.req = 4'b0011;
    repeat (4) cyc();
    b1.req = 4'b0010;
    cyc();
    chk("t5_grant", 32'(b1.grant), 32'h2);
    chk("t5_preempt", 32'(b1.preempt), 32'h0);
    b1.req = 4'b0000;
    cyc();
    chk("t5_idle_grant", 32'(b1.grant), 32'h0);
    chk("t5_idle_idx", 32'(b1.grant_idx), 32'h0);
    chk("t5_idle_valid", 32'(b1.grant_valid), 32'h0);
    // 6: asynchronous reset mid-grant
    do_reset();
    b0.req = 4'b0100;
    cyc();
    cyc();
    chk("t6_owner", 32'(b0.grant_idx), 32'h2);
    #2;
    b0.req = 4'hF;
    do_reset();
    chk("t6_reset_grant", 32'(b0.grant), 32'h0);
    cyc();
    chk("t6_first_idx", 32'(b0.grant_idx), 32'h0);
    // random: requests persist for a while then drop, re-raise later
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) begin
        b0.req[b] = b0.req[b] ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
        b1.req[b] = b1.req[b] ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
      end
      cyc();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
